// File: rtl/act_fifo_rd_arb_pkg.sv
// Shared constants and types for the activation FIFO read-side drainer.
package act_fifo_rd_arb_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int RD_NUM     = 2;
  localparam int BUF_DEPTH  = 2;
  localparam int CNT_W      = $clog2(BUF_DEPTH + 1);
  localparam int CRED_W     = CNT_W + 1;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int RD_ID_W = id_width(RD_NUM);

  // {write, dequeue} seen by one output buffer in a cycle
  typedef enum logic [1:0] {
    BUF_IDLE  = 2'b00,
    BUF_RD    = 2'b01,
    BUF_WR    = 2'b10,
    BUF_WR_RD = 2'b11
  } buf_op_e;

endpackage

// File: rtl/act_fifo_rd_arb_if.sv
// FIFO-side and PE-side stream bundle of the drainer; master is the drainer.
interface act_fifo_rd_arb_if #(
  parameter int DATA_WIDTH = act_fifo_rd_arb_pkg::DATA_WIDTH,
  parameter int RD_NUM     = act_fifo_rd_arb_pkg::RD_NUM
);
  logic [RD_NUM-1:0]            fifo_empty;
  logic [RD_NUM-1:0]            fifo_pop;
  logic [DATA_WIDTH-1:0]        fifo_data;
  logic [RD_NUM-1:0]            out_vld;
  logic [RD_NUM-1:0]            out_rdy;
  logic [RD_NUM*DATA_WIDTH-1:0] out_data;

  modport master (input fifo_empty, fifo_data, out_rdy,
                  output fifo_pop, out_vld, out_data);
  modport slave  (output fifo_empty, fifo_data, out_rdy,
                  input fifo_pop, out_vld, out_data);
endinterface

// File: rtl/act_rd_skid_buf.sv
// Two-entry per-reader output buffer with a registered head word.
module act_rd_skid_buf
  import act_fifo_rd_arb_pkg::*;
#(
  parameter int DATA_WIDTH = act_fifo_rd_arb_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_rdy,
  output logic                  o_vld,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CNT_W-1:0]      o_cnt
);

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_deq;
  buf_op_e               w_op;

  assign w_deq = i_rd_rdy && (r_cnt != '0);
  assign w_op  = buf_op_e'({i_wr_en, w_deq});

  // NOTE: the data words are reset too, not just the count, because the head drives out_data and must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      case (w_op)
        BUF_WR: begin
          if (r_cnt == '0) r_head <= i_wr_data;
          else             r_tail <= i_wr_data;
          r_cnt <= r_cnt + 1'b1;
        end
        BUF_RD: begin
          if (r_cnt == CNT_W'(BUF_DEPTH)) r_head <= r_tail;
          r_cnt <= r_cnt - 1'b1;
        end
        BUF_WR_RD: begin
          // cnt=1 replaces the head; cnt=2 shifts and appends
          if (r_cnt == CNT_W'(1)) begin
            r_head <= i_wr_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_wr_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_vld  = (r_cnt != '0);
  assign o_data = r_head;
  assign o_cnt  = r_cnt;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_wr_en && !i_clr && (r_cnt == CNT_W'(BUF_DEPTH)) && !w_deq));

endmodule

// File: rtl/act_fifo_rd_arb.sv
// Activation FIFO read drainer: one pop per cycle, 1-cycle SRAM latency, per-reader 2-entry buffers.
// Define ACT_RD_ARB_FIXED_PRI_EN for lowest-index-wins priority instead of round-robin.
module act_fifo_rd_arb
  import act_fifo_rd_arb_pkg::*;
#(
  parameter int DATA_WIDTH = act_fifo_rd_arb_pkg::DATA_WIDTH,
  parameter int RD_NUM     = act_fifo_rd_arb_pkg::RD_NUM,
  parameter int RD_ID_W    = id_width(RD_NUM)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Reset,
  act_fifo_rd_arb_if.master   bus
);

  logic                              r_inflight_vld;
  logic [RD_ID_W-1:0]                r_inflight_id;
  logic [RD_NUM-1:0]                 w_vld;
  logic [RD_NUM-1:0]                 w_deq;
  logic [RD_NUM-1:0]                 w_hit;
  logic [RD_NUM-1:0]                 w_wr_en;
  logic [RD_NUM-1:0]                 w_elig;
  logic [RD_NUM-1:0]                 w_pop;
  logic [RD_NUM-1:0][CNT_W-1:0]      w_cnt;
  logic [RD_NUM-1:0][DATA_WIDTH-1:0] w_out_data;
  logic                              w_gnt_vld;
  logic [RD_ID_W-1:0]                w_gnt_id;
  logic                              w_fire;

  for (genvar gi = 0; gi < RD_NUM; gi++) begin : g_rd
    logic [CRED_W-1:0] w_cred_next;

    assign w_deq[gi]   = w_vld[gi] && bus.out_rdy[gi];
    assign w_hit[gi]   = r_inflight_vld && (r_inflight_id == RD_ID_W'(gi));
    assign w_wr_en[gi] = w_hit[gi] && !Reset;
    // Credit after this cycle's dequeue: a draining full buffer may be granted
    assign w_cred_next = CRED_W'(w_cnt[gi]) - CRED_W'(w_deq[gi]) + CRED_W'(w_hit[gi]);
    assign w_elig[gi]  = !bus.fifo_empty[gi] && (w_cred_next < CRED_W'(BUF_DEPTH));

    act_rd_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clr     (Reset),
      .i_wr_en   (w_wr_en[gi]),
      .i_wr_data (bus.fifo_data),
      .i_rd_rdy  (bus.out_rdy[gi]),
      .o_vld     (w_vld[gi]),
      .o_data    (w_out_data[gi]),
      .o_cnt     (w_cnt[gi])
    );
  end

`ifndef ACT_RD_ARB_FIXED_PRI_EN
  logic [RD_ID_W-1:0] r_rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (Reset) begin
      r_rr_ptr <= '0;
    end else if (w_fire) begin
      r_rr_ptr <= (w_gnt_id == RD_ID_W'(RD_NUM - 1)) ? '0 : w_gnt_id + 1'b1;
    end
  end
`endif

  // NOTE: every output of this block is defaulted before the search loop, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    logic [RD_ID_W-1:0] idx;
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    idx       = '0;
    for (int k = 0; k < RD_NUM; k++) begin
`ifdef ACT_RD_ARB_FIXED_PRI_EN
      idx = RD_ID_W'(k);
`else
      idx = RD_ID_W'((int'(r_rr_ptr) + k) % RD_NUM);
`endif
      if (!w_gnt_vld && w_elig[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = idx;
      end
    end
  end

  assign w_fire = w_gnt_vld && !Reset;
  assign w_pop  = w_fire ? (RD_NUM'(1) << w_gnt_id) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight_vld <= 1'b0;
      r_inflight_id  <= '0;
    end else if (Reset) begin
      r_inflight_vld <= 1'b0;
      r_inflight_id  <= '0;
    end else begin
      r_inflight_vld <= w_fire;
      if (w_fire) r_inflight_id <= w_gnt_id;
    end
  end

  assign bus.fifo_pop = w_pop;
  assign bus.out_vld  = w_vld;
  assign bus.out_data = w_out_data;

  a_no_empty_pop: assert property (@(posedge clk) disable iff (!rst_n)
    (w_pop & bus.fifo_empty) == '0);

endmodule

// File: tb/tb_act_fifo_rd_arb.sv
// Bench for act_fifo_rd_arb: queue-based reference model checked every cycle plus directed literal checks.
module tb_act_fifo_rd_arb;
  import act_fifo_rd_arb_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int RN = RD_NUM;
  typedef logic [DW-1:0] word_t;
  localparam word_t GARBAGE = word_t'(64'hDEAD_BEEF_0BAD_F00D);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic Reset = 1'b0;
  always #5 clk = ~clk;

  act_fifo_rd_arb_if #(.DATA_WIDTH(DW), .RD_NUM(RN)) bus ();

  act_fifo_rd_arb #(.DATA_WIDTH(DW), .RD_NUM(RN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // environment: per-reader FIFO contents
  word_t src[RN][$];
  // reference model
  word_t m_buf[RN][$];
  bit    m_inf_vld;
  int    m_inf_id;
  word_t m_inf_data;
  int    m_rr;
  // observation logs
  word_t rx[RN][$];
  int    gnt_log[$];
  logic [RN-1:0] last_pop, last_vld, pop_smp;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic upd_empty();
    for (int i = 0; i < RN; i++) bus.fifo_empty[i] = (src[i].size() == 0);
  endtask

  task automatic load(input int i, input word_t base, input int n);
    for (int k = 0; k < n; k++) src[i].push_back(word_t'(base + k));
    upd_empty();
  endtask

  task automatic clear_logs();
    for (int i = 0; i < RN; i++) rx[i].delete();
    gnt_log.delete();
  endtask

  // Compare DUT against the model for this cycle, then advance the model across the edge
  task automatic model_step();
    logic [RN-1:0] exp_pop, dq, el;
    int cn, g, id;
    exp_pop = '0;
    g = 0;
    for (int i = 0; i < RN; i++) begin
      dq[i] = (m_buf[i].size() > 0) && bus.out_rdy[i];
      cn = m_buf[i].size() - int'(dq[i]) + ((m_inf_vld && m_inf_id == i) ? 1 : 0);
      el[i] = (src[i].size() > 0) && (cn < BUF_DEPTH);
    end
    if (!Reset) begin
      for (int k = 0; k < RN; k++) begin
`ifdef ACT_RD_ARB_FIXED_PRI_EN
        id = k;
`else
        id = (m_rr + k) % RN;
`endif
        if (exp_pop == '0 && el[id]) begin
          exp_pop[id] = 1'b1;
          g = id;
        end
      end
    end
    check("fifo_pop", bus.fifo_pop, exp_pop);
    for (int i = 0; i < RN; i++) begin
      check($sformatf("out_vld%0d", i), bus.out_vld[i], m_buf[i].size() > 0);
      if (m_buf[i].size() > 0)
        check($sformatf("out_data%0d", i), bus.out_data[i*DW +: DW], m_buf[i][0]);
      if (bus.out_vld[i] && bus.out_rdy[i]) rx[i].push_back(bus.out_data[i*DW +: DW]);
      if (bus.fifo_pop[i]) gnt_log.push_back(i);
    end
    last_pop = bus.fifo_pop;
    last_vld = bus.out_vld;
    pop_smp  = bus.fifo_pop;

    if (Reset) begin
      for (int i = 0; i < RN; i++) m_buf[i].delete();
      m_inf_vld = 1'b0;
      m_rr = 0;
    end else begin
      for (int i = 0; i < RN; i++) if (dq[i]) void'(m_buf[i].pop_front());
      if (m_inf_vld) m_buf[m_inf_id].push_back(m_inf_data);
      if (exp_pop != '0) begin
        m_inf_vld  = 1'b1;
        m_inf_id   = g;
        m_inf_data = src[g][0];
        m_rr       = (g + 1) % RN;
      end else begin
        m_inf_vld = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    word_t fd;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    fd = GARBAGE;
    for (int i = 0; i < RN; i++)
      if (pop_smp[i] && src[i].size() > 0) fd = src[i].pop_front();
    bus.fifo_data = fd;
    upd_empty();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_reset();
    for (int i = 0; i < RN; i++) src[i].delete();
    upd_empty();
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    clear_logs();
  endtask

  task automatic check_rx(input int i, input word_t base, input int n, input string nm);
    check({nm, "_count"}, rx[i].size(), n);
    for (int k = 0; k < n && k < rx[i].size(); k++)
      check($sformatf("%s_word%0d", nm, k), rx[i][k], word_t'(base + k));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ph, vh;
    int n1;
    int exp_seq[4];
    bus.out_rdy   = '0;
    bus.fifo_data = GARBAGE;
    upd_empty();
    m_inf_vld = 1'b0;
    m_inf_id  = 0;
    m_rr      = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_pop", bus.fifo_pop, 0);
    check("rst_vld", bus.out_vld, 0);
    check("rst_data", bus.out_data, 0);
    @(posedge clk);
    #1;

    // single reader streams one word per cycle
    bus.out_rdy = 2'b01;
    do_reset();
    load(0, word_t'('hA0), 4);
    ph = '0;
    vh = '0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      ph[k] = last_pop[0];
      vh[k] = last_vld[0];
    end
    check("t1_pop_hist", ph, 8'b0000_1111);
    check("t1_vld_hist", vh, 8'b0011_1100);
    check_rx(0, word_t'('hA0), 4, "t1_rx0");

    // both readers busy
    bus.out_rdy = 2'b11;
    do_reset();
    load(0, word_t'('hB0), 4);
    load(1, word_t'('hC0), 4);
    run(14);
`ifdef ACT_RD_ARB_FIXED_PRI_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    check("t2_gnt_count", gnt_log.size(), 8);
    for (int k = 0; k < 4 && k < gnt_log.size(); k++)
      check($sformatf("t2_gnt%0d", k), gnt_log[k], exp_seq[k]);
    check_rx(0, word_t'('hB0), 4, "t2_rx0");
    check_rx(1, word_t'('hC0), 4, "t2_rx1");

    // back-pressure caps a reader at two outstanding words
    bus.out_rdy = 2'b01;
    do_reset();
    load(1, word_t'('hD0), 5);
    run(8);
    n1 = 0;
    foreach (gnt_log[k]) if (gnt_log[k] == 1) n1++;
    check("t3_pops_stalled", n1, 2);
    check("t3_pop_idle", last_pop, 0);
    check("t3_vld1", last_vld[1], 1);
    bus.out_rdy = 2'b11;
    run(12);
    check_rx(1, word_t'('hD0), 5, "t3_rx1");

    // head hold under stall, then write-with-dequeue
    bus.out_rdy = 2'b00;
    do_reset();
    load(0, word_t'('hE0), 5);
    run(4);
    check("t4_head_a", bus.out_data[DW-1:0], word_t'('hE0));
    run(2);
    check("t4_head_b", bus.out_data[DW-1:0], word_t'('hE0));
    bus.out_rdy = 2'b01;
    cycle();
    bus.out_rdy = 2'b00;
    cycle();
    bus.out_rdy = 2'b01;
    run(10);
    check_rx(0, word_t'('hE0), 5, "t4_rx0");

    // Reset the cycle after a pop drops the returning word and restarts at reader0
    bus.out_rdy = 2'b11;
    do_reset();
    load(0, word_t'('hF0), 3);
    cycle();
    check("t5_first_pop", last_pop, 2'b01);
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    check("t5_reset_pop", last_pop, 0);
    load(1, word_t'('h70), 1);
    cycle();
    check("t5_after_pop", last_pop, 2'b01);
    check("t5_after_vld", last_vld, 0);
    run(10);
    check_rx(0, word_t'('hF1), 2, "t5_rx0");
    check_rx(1, word_t'('h70), 1, "t5_rx1");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/act_fifo_rd_arb.md
Name: act_fifo_rd_arb

Overview:
- Read-side drainer for the multi-read activation FIFO, which has one shared SRAM read port and one registered read cycle.
- Grants at most one pop per cycle among RD_NUM readers.
- Tracks the one-cycle SRAM read latency and steers returning data into a per-reader 2-entry output buffer.
- Each PE-side consumer sees a plain valid/ready stream.
- Sits between the activation FIFO's pop/empty/data_out and the PE activation inputs.

Parameters:
- DATA_WIDTH, 64, width of one FIFO/SRAM word.
- RD_NUM, 2, number of readers; legal range 2..8.
- RD_ID_W, 1, grant index width; equals clog2(RD_NUM).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- Reset  in  1  synchronous clear; highest priority after rst_n
- fifo_empty  in  RD_NUM  per-reader empty flags from the FIFO
- fifo_pop  out  RD_NUM  one-hot-or-zero pop vector to the FIFO
- fifo_data  in  DATA_WIDTH  SRAM read data, valid the cycle after a pop
- out_vld  out  RD_NUM  per-reader output valid
- out_rdy  in  RD_NUM  per-reader consumer ready
- out_data  out  RD_NUM*DATA_WIDTH  per-reader head word; reader i uses slice [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset values: fifo_pop=0, out_vld=0, out_data=0, all buffers empty, rr_ptr=0, inflight_vld=0.
- Reset=1 has the same effect at the clock edge. fifo_pop is forced to 0 combinationally while Reset=1. Data returning in the Reset cycle or the cycle after it is discarded.
- Per-reader credit: cred[i] = buf_cnt[i] + (inflight_vld && inflight_id==i); range 0..2.
- Reader i is eligible when !fifo_empty[i] and cred_next[i] < 2. cred_next is taken after this cycle's out_vld&out_rdy dequeue, so a full buffer that is being drained can still be granted.
- Arbitration:
  - Round-robin starting at rr_ptr over eligible readers.
  - fifo_pop is combinational, with at most one bit set.
  - On a grant, rr_ptr <= grant_id+1 (wraps to 0 after RD_NUM-1).
  - No grant leaves rr_ptr unchanged.
- Latency: a pop in cycle N registers inflight_vld=1 and inflight_id=grant_id. In cycle N+1, fifo_data is written into the tail of buffer inflight_id. out_vld rises in cycle N+2.
- Throughput: with one reader continuously ready and everyone else idle, that reader receives one word per cycle.
- Buffer: 2-entry FIFO per reader, head is registered; out_data holds the head.
- Simultaneous write and dequeue on the same buffer:
  - cnt=1: the head is replaced by the incoming word; cnt stays 1.
  - cnt=2: the entry shifts, the incoming word is appended, and cnt stays 2.
- out_data is stable while out_vld=1 and out_rdy=0.
- Never pops an empty reader. Never overflows a buffer; the credit rule guarantees this.
- Buffer overflow and pop-while-empty are assertion-checked errors.

Optional Feature:
- Macro ACT_RD_ARB_FIXED_PRI_EN.
- Defined: fixed priority, where the lowest eligible index wins. rr_ptr is not implemented. This matches an SRAM address mux that favours pop[0].
- Undefined: round-robin as specified above.

Decomposition:
- Shared package/header: DATA_WIDTH default, RD_NUM default, RD_ID_W derivation, BUF_DEPTH=2 constant.
- Natural sub-module: act_rd_skid_buf, one per reader. Ports: wr_en, wr_data, rd_rdy, vld, data, cnt. Instantiated RD_NUM times in a generate loop.
- Arbiter stays inline.

Test Plan:
- Reader0 has 4 words (0xA0..0xA3), out_rdy[0]=1, reader1 empty → pops in cycles 1-4, out_vld[0] in cycles 3-6, data in order 0xA0..0xA3.
- Both readers non-empty, both ready, round-robin build → pops alternate 0,1,0,1. Each reader's word order is preserved and no word is duplicated.
- out_rdy[1]=0, reader1 has 5 words → exactly 2 pops to reader1, then fifo_pop[1] stays 0. Raising out_rdy resumes one pop per dequeue, and no data is lost.
- Simultaneous write of word W and dequeue at cnt=1 and at cnt=2 → out_data sequence is exact and cnt is unchanged.
- Reset asserted the cycle after a pop → returning word dropped, out_vld=0, rr_ptr=0, next grant goes to reader0.
- Build with ACT_RD_ARB_FIXED_PRI_EN, both readers always eligible → reader0 is granted every cycle and reader1 never.
